// File: rtl/spi_xfer_ctrl.sv
// Button-driven sequencer for one full-duplex MSB-first serial transfer.
// Optional SPI_LOOPBACK_EN: receive path taps serial_out instead of serial_in.
module spi_xfer_ctrl #(
  parameter int DATA_W  = 16,
  parameter int CLK_DIV = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_btn,
  input  logic              start_btn,
  input  logic [DATA_W-1:0] pb_in,
  input  logic              serial_in,
  output logic              serial_out,
  output logic              sclk,
  output logic              cs_n,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] tx_word,
  output logic [DATA_W-1:0] rx_word
);

  localparam int BIT_W = $clog2(DATA_W + 1);
  localparam int DIV_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_HOLD  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t              state_r, state_s;
  logic [DIV_W-1:0]    div_r, div_s;
  logic [BIT_W-1:0]    bit_r, bit_s;
  logic                sclk_r, sclk_s;
  logic                so_r, so_s;
  logic                cs_n_r, cs_n_s;
  logic                busy_r, busy_s;
  logic                done_r, done_s;
  logic                err_r, err_s;
  logic                loaded_r, loaded_s;
  logic [DATA_W-1:0]   tx_r, tx_s;
  logic [DATA_W-1:0]   txsh_r, txsh_s;
  logic [DATA_W-1:0]   rx_r, rx_s;
  logic [DATA_W-1:0]   rxsh_r, rxsh_s;

  logic load_meta_r, load_sync_r, load_prev_r;
  logic start_meta_r, start_sync_r, start_prev_r;
  logic load_pulse_s, start_pulse_s;
  logic div_last_s;
  logic rx_bit_s;

  // Two-flop synchronizers plus edge-history flops for both buttons
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      load_meta_r  <= 1'b0;
      load_sync_r  <= 1'b0;
      load_prev_r  <= 1'b0;
      start_meta_r <= 1'b0;
      start_sync_r <= 1'b0;
      start_prev_r <= 1'b0;
    end else begin
      load_meta_r  <= load_btn;
      load_sync_r  <= load_meta_r;
      load_prev_r  <= load_sync_r;
      start_meta_r <= start_btn;
      start_sync_r <= start_meta_r;
      start_prev_r <= start_sync_r;
    end
  end

  assign load_pulse_s  = load_sync_r & ~load_prev_r;
  assign start_pulse_s = start_sync_r & ~start_prev_r;
  assign div_last_s    = (div_r == DIV_W'(CLK_DIV - 1));

`ifdef SPI_LOOPBACK_EN
  assign rx_bit_s = so_r;
`else
  assign rx_bit_s = serial_in;
`endif

  // Next-state and next-output logic; every output is registered below
  always_comb begin
    state_s  = state_r;
    div_s    = div_r;
    bit_s    = bit_r;
    sclk_s   = sclk_r;
    so_s     = so_r;
    cs_n_s   = cs_n_r;
    err_s    = err_r;
    loaded_s = loaded_r;
    tx_s     = tx_r;
    txsh_s   = txsh_r;
    rx_s     = rx_r;
    rxsh_s   = rxsh_r;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        // load takes priority over a coincident start
        if (load_pulse_s) begin
          tx_s     = pb_in;
          loaded_s = 1'b1;
          err_s    = 1'b0;
          state_s  = ST_IDLE;
        end else if (start_pulse_s) begin
          if (loaded_r) begin
            state_s = ST_SETUP;
            err_s   = 1'b0;
            cs_n_s  = 1'b0;
            sclk_s  = 1'b0;
            so_s    = tx_r[DATA_W-1];
            txsh_s  = tx_r;
            rxsh_s  = {DATA_W{1'b0}};
            div_s   = {DIV_W{1'b0}};
            bit_s   = {BIT_W{1'b0}};
          end else begin
            err_s = 1'b1;
          end
        end else begin
          state_s = state_r;
        end
      end
      ST_SETUP: begin
        if (div_last_s) begin
          div_s   = {DIV_W{1'b0}};
          state_s = ST_SHIFT;
        end else begin
          div_s = div_r + {{(DIV_W-1){1'b0}}, 1'b1};
        end
      end
      ST_SHIFT: begin
        if (div_last_s) begin
          div_s = {DIV_W{1'b0}};
          if (!sclk_r) begin
            sclk_s = 1'b1;
            rxsh_s = {rxsh_r[DATA_W-2:0], rx_bit_s};
          end else begin
            sclk_s = 1'b0;
            txsh_s = {txsh_r[DATA_W-2:0], 1'b0};
            so_s   = txsh_r[DATA_W-2];
            bit_s  = bit_r + {{(BIT_W-1){1'b0}}, 1'b1};
            if (bit_r == BIT_W'(DATA_W - 1)) begin
              state_s = ST_HOLD;
            end else begin
              state_s = ST_SHIFT;
            end
          end
        end else begin
          div_s = div_r + {{(DIV_W-1){1'b0}}, 1'b1};
        end
      end
      ST_HOLD: begin
        if (div_last_s) begin
          div_s    = {DIV_W{1'b0}};
          bit_s    = {BIT_W{1'b0}};
          cs_n_s   = 1'b1;
          so_s     = 1'b0;
          rx_s     = rxsh_r;
          loaded_s = 1'b0;
          state_s  = ST_DONE;
        end else begin
          div_s = div_r + {{(DIV_W-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_s = ST_IDLE;
        cs_n_s  = 1'b1;
        sclk_s  = 1'b0;
      end
    endcase
    busy_s = (state_s == ST_SETUP) || (state_s == ST_SHIFT) || (state_s == ST_HOLD);
    done_s = (state_s == ST_DONE);
  end

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r  <= ST_IDLE;
      div_r    <= {DIV_W{1'b0}};
      bit_r    <= {BIT_W{1'b0}};
      sclk_r   <= 1'b0;
      so_r     <= 1'b0;
      cs_n_r   <= 1'b1;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      err_r    <= 1'b0;
      loaded_r <= 1'b0;
      tx_r     <= {DATA_W{1'b0}};
      txsh_r   <= {DATA_W{1'b0}};
      rx_r     <= {DATA_W{1'b0}};
      rxsh_r   <= {DATA_W{1'b0}};
    end else begin
      state_r  <= state_s;
      div_r    <= div_s;
      bit_r    <= bit_s;
      sclk_r   <= sclk_s;
      so_r     <= so_s;
      cs_n_r   <= cs_n_s;
      busy_r   <= busy_s;
      done_r   <= done_s;
      err_r    <= err_s;
      loaded_r <= loaded_s;
      tx_r     <= tx_s;
      txsh_r   <= txsh_s;
      rx_r     <= rx_s;
      rxsh_r   <= rxsh_s;
    end
  end

  assign serial_out = so_r;
  assign sclk       = sclk_r;
  assign cs_n       = cs_n_r;
  assign busy       = busy_r;
  assign done       = done_r;
  assign err        = err_r;
  assign tx_word    = tx_r;
  assign rx_word    = rx_r;

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Directed bench for spi_xfer_ctrl: button sequencing, full transfers with a
// serial slave model, timing of cs_n/done, ignored presses and async reset.
module tb_spi_xfer_ctrl;
  localparam int W   = 16;
  localparam int C   = 4;
  localparam int LAT = C * (2 * W + 2);

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          load_btn = 1'b0;
  logic          start_btn = 1'b0;
  logic [W-1:0]  pb_in = 16'h0000;
  logic          serial_in = 1'b0;
  logic          serial_out, sclk, cs_n, busy, done, err;
  logic [W-1:0]  tx_word, rx_word;

  int            n_checks = 0;
  int            n_err = 0;
  logic [W-1:0]  slave_word = 16'h0000;
  logic [W-1:0]  sl_sh = 16'h0000;
  logic [W-1:0]  mosi_cap = 16'h0000;
  int            sclk_rises = 0;

  spi_xfer_ctrl #(.DATA_W(W), .CLK_DIV(C)) dut (
    .clk(clk), .reset(reset), .load_btn(load_btn), .start_btn(start_btn),
    .pb_in(pb_in), .serial_in(serial_in), .serial_out(serial_out),
    .sclk(sclk), .cs_n(cs_n), .busy(busy), .done(done), .err(err),
    .tx_word(tx_word), .rx_word(rx_word)
  );

  always #5 clk = ~clk;

  // Slave: presents MSB at cs_n fall, advances on each falling sclk
  always begin
    @(negedge cs_n);
    sl_sh = slave_word;
    serial_in = sl_sh[W-1];
    while (cs_n === 1'b0) begin
      @(negedge sclk or posedge cs_n);
      if (cs_n === 1'b0) begin
        sl_sh = {sl_sh[W-2:0], 1'b0};
        serial_in = sl_sh[W-1];
      end else begin
        serial_in = 1'b0;
      end
    end
  end

  // Capture MOSI on rising sclk, as the device would
  always @(posedge sclk) begin
    mosi_cap = {mosi_cap[W-2:0], serial_out};
    sclk_rises = sclk_rises + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic press(input logic ld, input logic st);
    load_btn  = ld;
    start_btn = st;
    repeat (5) @(negedge clk);
    load_btn  = 1'b0;
    start_btn = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  // Starts a transfer and measures SETUP-entry-to-done and cs_n-low cycles
  task automatic run_xfer(input bit disturb, output int lat_o, output int low_o);
    int n;
    bit seen;
    lat_o = -1;
    low_o = 0;
    seen  = 1'b0;
    start_btn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (cs_n === 1'b0) begin
        seen = 1'b1;
        break;
      end
    end
    chk("setup_entered", {31'd0, seen}, 32'd1);
    if (seen) begin
      low_o = 1;
      n = 0;
      while (done !== 1'b1 && n < 400) begin
        @(negedge clk);
        n++;
        if (n == 3) start_btn = 1'b0;
        if (disturb && n == 40) begin
          load_btn = 1'b1; start_btn = 1'b1; pb_in = 16'hFFFF;
        end
        if (disturb && n == 48) begin
          load_btn = 1'b0; start_btn = 1'b0;
        end
        if (cs_n === 1'b0) low_o++;
      end
      if (done === 1'b1) lat_o = n;
    end
    start_btn = 1'b0;
    load_btn  = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int lat, low, r0, n;
    logic [W-1:0] exp_rx;

    repeat (3) @(negedge clk);
    chk("rst_cs_n", {31'd0, cs_n}, 32'd1);
    chk("rst_sclk", {31'd0, sclk}, 32'd0);
    chk("rst_mosi", {31'd0, serial_out}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_tx", {16'd0, tx_word}, 32'd0);
    chk("rst_rx", {16'd0, rx_word}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // start without a loaded word
    r0 = sclk_rises;
    press(1'b0, 1'b1);
    chk("noload_err", {31'd0, err}, 32'd1);
    chk("noload_cs_n", {31'd0, cs_n}, 32'd1);
    chk("noload_busy", {31'd0, busy}, 32'd0);
    chk("noload_sclk", sclk_rises - r0, 32'd0);
    pb_in = 16'h0001;
    press(1'b1, 1'b0);
    chk("load_clr_err", {31'd0, err}, 32'd0);
    chk("load_tx1", {16'd0, tx_word}, 32'h0001);

    // main transfer A55A out, 3C96 in
    pb_in = 16'hA55A;
    press(1'b1, 1'b0);
    slave_word = 16'h3C96;
    r0 = sclk_rises;
    run_xfer(1'b0, lat, low);
`ifdef SPI_LOOPBACK_EN
    exp_rx = 16'hA55A;
`else
    exp_rx = 16'h3C96;
`endif
    chk("a55a_latency", lat, LAT);
    chk("a55a_cs_low", low, LAT);
    chk("a55a_mosi", {16'd0, mosi_cap}, 32'h0000A55A);
    chk("a55a_rx", {16'd0, rx_word}, {16'd0, exp_rx});
    chk("a55a_sclk_cnt", sclk_rises - r0, 32'd16);
    chk("a55a_done", {31'd0, done}, 32'd1);
    chk("a55a_busy", {31'd0, busy}, 32'd0);
    chk("a55a_cs_n", {31'd0, cs_n}, 32'd1);

    // start in DONE without reload
    press(1'b0, 1'b1);
    chk("done_restart_err", {31'd0, err}, 32'd1);
    chk("done_restart_done", {31'd0, done}, 32'd1);

    // simultaneous load and start: load wins
    pb_in = 16'h1234;
    r0 = sclk_rises;
    press(1'b1, 1'b1);
    chk("both_tx", {16'd0, tx_word}, 32'h00001234);
    chk("both_busy", {31'd0, busy}, 32'd0);
    chk("both_done", {31'd0, done}, 32'd0);
    chk("both_cs_n", {31'd0, cs_n}, 32'd1);
    chk("both_err", {31'd0, err}, 32'd0);
    chk("both_no_sclk", sclk_rises - r0, 32'd0);
    slave_word = 16'h0000;
    run_xfer(1'b0, lat, low);
    chk("both_run_lat", lat, LAT);
    chk("both_run_mosi", {16'd0, mosi_cap}, 32'h00001234);

    // presses during SHIFT are ignored
    pb_in = 16'h0F0F;
    press(1'b1, 1'b0);
    slave_word = 16'h5A5A;
    run_xfer(1'b1, lat, low);
`ifdef SPI_LOOPBACK_EN
    exp_rx = 16'h0F0F;
`else
    exp_rx = 16'h5A5A;
`endif
    chk("ign_tx", {16'd0, tx_word}, 32'h00000F0F);
    chk("ign_lat", lat, LAT);
    chk("ign_mosi", {16'd0, mosi_cap}, 32'h00000F0F);
    chk("ign_rx", {16'd0, rx_word}, {16'd0, exp_rx});

    // serial_in tied low: loopback echoes tx, otherwise zero
    slave_word = 16'h0000;
    pb_in = 16'hFFFF;
    press(1'b1, 1'b0);
    run_xfer(1'b0, lat, low);
`ifdef SPI_LOOPBACK_EN
    exp_rx = 16'hFFFF;
`else
    exp_rx = 16'h0000;
`endif
    chk("tie0_ffff_rx", {16'd0, rx_word}, {16'd0, exp_rx});
    pb_in = 16'h8001;
    press(1'b1, 1'b0);
    run_xfer(1'b0, lat, low);
`ifdef SPI_LOOPBACK_EN
    exp_rx = 16'h8001;
`else
    exp_rx = 16'h0000;
`endif
    chk("tie0_8001_rx", {16'd0, rx_word}, {16'd0, exp_rx});

    // async reset after five bits of SHIFT
    pb_in = 16'h00FF;
    press(1'b1, 1'b0);
    slave_word = 16'hFFFF;
    start_btn = 1'b1;
    n = 0;
    while (cs_n !== 1'b0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("mid_setup_seen", {31'd0, cs_n}, 32'd0);
    for (int k = 0; k < 46; k++) begin
      @(negedge clk);
      if (k == 2) start_btn = 1'b0;
    end
    chk("mid_busy_before", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    #1;
    chk("mid_rst_cs_n", {31'd0, cs_n}, 32'd1);
    chk("mid_rst_sclk", {31'd0, sclk}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_rx", {16'd0, rx_word}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    press(1'b0, 1'b1);
    chk("mid_after_err", {31'd0, err}, 32'd1);
    chk("mid_after_cs_n", {31'd0, cs_n}, 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
